// File: rtl/alarm_sequencer_pkg.sv
// ============================================================================
// Module : alarm_sequencer_pkg
// Brief  : Shared state encoding and time-field constants for the alarm sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alarm_sequencer_pkg;

  localparam int TIME_W     = 6;
  localparam int MIN_PER_HR = 60;
  localparam int HR_PER_DAY = 24;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RINGING  = 3'd2,
    ST_REARM    = 3'd3,
    ST_SNOOZE   = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_sequencer_time_add_min.sv
// ============================================================================
// Module : time_add_min
// Brief  : Combinational hh:mm + N minutes (N in 0..59) with midnight wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module time_add_min
  import alarm_sequencer_pkg::*;
(
  input  logic [TIME_W-1:0] i_hour,
  input  logic [TIME_W-1:0] i_min,
  input  logic [TIME_W-1:0] i_add_min,
  output logic [TIME_W-1:0] o_hour,
  output logic [TIME_W-1:0] o_min
);

  logic [TIME_W:0]   w_min_sum;
  logic [TIME_W:0]   w_min_wrap;
  logic [TIME_W-1:0] w_hour_inc;

  always_comb begin
    w_min_sum  = {1'b0, i_min} + {1'b0, i_add_min};
    w_min_wrap = w_min_sum - (TIME_W + 1)'(MIN_PER_HR);
    w_hour_inc = i_hour + TIME_W'(1);
    o_hour     = i_hour;
    o_min      = w_min_sum[TIME_W-1:0];
    if (w_min_sum >= (TIME_W + 1)'(MIN_PER_HR)) begin
      o_min  = w_min_wrap[TIME_W-1:0];
      o_hour = (w_hour_inc == TIME_W'(HR_PER_DAY)) ? '0 : w_hour_inc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alarm_sequencer.sv
// ============================================================================
// Module : alarm_sequencer
// Brief  : Drives the alarm comparator and owns ring, snooze and dismiss.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              alarm_enable,
  input  logic              snooze_btn,
  input  logic              stop_btn,
  input  logic [TIME_W-1:0] set_hour,
  input  logic [TIME_W-1:0] set_min,
  input  logic [TIME_W-1:0] now_hour,
  input  logic [TIME_W-1:0] now_min,
  input  logic              cmp_alarm,
  output logic              cmp_enable,
  output logic [TIME_W-1:0] cmp_hour,
  output logic [TIME_W-1:0] cmp_min,
  output logic              buzzer,
  output logic              ringing,
  output logic              snoozing,
  output logic [1:0]        snooze_cnt
);

  localparam logic [7:0]        c_RING_TIMEOUT = 8'(RING_TIMEOUT);
  localparam logic [2:0]        c_MAX_SNOOZE   = 3'(MAX_SNOOZE);
  localparam logic [TIME_W-1:0] c_SNOOZE_MIN   = TIME_W'(SNOOZE_MIN);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_ring_cnt;
  logic [TIME_W-1:0] r_done_min;
  logic [TIME_W-1:0] w_snz_hour;
  logic [TIME_W-1:0] w_snz_min;
  logic              w_timeout;
  logic              w_snooze_ok;

  time_add_min u_snooze_add (
    .i_hour    (now_hour),
    .i_min     (now_min),
    .i_add_min (c_SNOOZE_MIN),
    .o_hour    (w_snz_hour),
    .o_min     (w_snz_min)
  );

  always_comb begin
    w_next_state = r_state;
    w_timeout    = (r_ring_cnt == c_RING_TIMEOUT);
    w_snooze_ok  = ({1'b0, snooze_cnt} < c_MAX_SNOOZE);
    case (r_state)
      ST_DISABLED: if (alarm_enable) w_next_state = ST_ARMED;
      ST_ARMED:    if (cmp_alarm) w_next_state = ST_RINGING;
      ST_RINGING: begin
        if (stop_btn)
          w_next_state = ST_DONE;
        else if (snooze_btn || w_timeout)
          w_next_state = w_snooze_ok ? ST_REARM : ST_DONE;
      end
      ST_REARM:    w_next_state = ST_SNOOZE;
      ST_SNOOZE: begin
        if (stop_btn)       w_next_state = ST_DONE;
        else if (cmp_alarm) w_next_state = ST_RINGING;
      end
      // Hold off re-arming until the minute rolls over, so a still-matching
      // comparator cannot immediately re-trigger.
      ST_DONE:     if (now_min != r_done_min) w_next_state = ST_ARMED;
      default:     w_next_state = ST_DISABLED;
    endcase
    if (!alarm_enable) w_next_state = ST_DISABLED;
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_DISABLED;
      r_ring_cnt <= '0;
      r_done_min <= '0;
      cmp_enable <= 1'b0;
      cmp_hour   <= '0;
      cmp_min    <= '0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      cmp_enable <= (w_next_state == ST_ARMED) || (w_next_state == ST_RINGING) ||
                    (w_next_state == ST_SNOOZE);
      ringing    <= (w_next_state == ST_RINGING);
      snoozing   <= (w_next_state == ST_REARM) || (w_next_state == ST_SNOOZE);

      case (w_next_state)
        ST_DISABLED, ST_ARMED: begin
          cmp_hour <= set_hour;
          cmp_min  <= set_min;
        end
        ST_REARM: begin
          cmp_hour <= w_snz_hour;
          cmp_min  <= w_snz_min;
        end
        default: ;
      endcase

      if (w_next_state == ST_RINGING) begin
        if (r_state != ST_RINGING) begin
          buzzer     <= 1'b1;
          r_ring_cnt <= '0;
        end else if (tick_1hz) begin
          buzzer     <= ~buzzer;
          r_ring_cnt <= r_ring_cnt + 8'd1;
        end
      end else begin
        buzzer <= 1'b0;
      end

      if (w_next_state == ST_DONE || w_next_state == ST_DISABLED)
        snooze_cnt <= '0;
      else if (w_next_state == ST_REARM && r_state != ST_REARM)
        snooze_cnt <= snooze_cnt + 2'd1;

      if (w_next_state == ST_DONE && r_state != ST_DONE)
        r_done_min <= now_min;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
// ============================================================================
// Module : tb_alarm_sequencer
// Brief  : Self-checking bench for alarm_sequencer with an expected-output queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_sequencer;

  logic       clk;
  logic       reset;
  logic       tick_1hz, alarm_enable, snooze_btn, stop_btn, cmp_alarm;
  logic [5:0] set_hour, set_min, now_hour, now_min;
  logic       cmp_enable, buzzer, ringing, snoozing;
  logic [5:0] cmp_hour, cmp_min;
  logic [1:0] snooze_cnt;

  typedef struct packed {
    logic       cmp_enable;
    logic [5:0] cmp_hour;
    logic [5:0] cmp_min;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;
  } outs_t;

  outs_t exp_q[$];
  outs_t obs;
  outs_t exp_v;
  int    n_cmp = 0;
  int    n_bad = 0;

  assign obs = {cmp_enable, cmp_hour, cmp_min, buzzer, ringing, snoozing, snooze_cnt};

  alarm_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .alarm_enable (alarm_enable),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .set_hour     (set_hour),
    .set_min      (set_min),
    .now_hour     (now_hour),
    .now_min      (now_min),
    .cmp_alarm    (cmp_alarm),
    .cmp_enable   (cmp_enable),
    .cmp_hour     (cmp_hour),
    .cmp_min      (cmp_min),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_cnt   (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input logic en, input int h, input int m, input logic bz,
                               input logic rg, input logic sz, input int cnt);
    outs_t o;
    o.cmp_enable = en;
    o.cmp_hour   = 6'(h);
    o.cmp_min    = 6'(m);
    o.buzzer     = bz;
    o.ringing    = rg;
    o.snoozing   = sz;
    o.snooze_cnt = 2'(cnt);
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; alarm_enable = 1'b0; tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cmp_alarm = 1'b0; set_hour = 6'd7; set_min = 6'd30; now_hour = 6'd7; now_min = 6'd29;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    reset = 1'b1;
    exp_q.push_back(mk(0, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL disabled_track: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_ring_stop();
    alarm_enable = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL armed: got %h want %h", obs, exp_v); end
    now_min = 6'd30; cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 1, 1, 0, 0)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ring_entry: got %h want %h", obs, exp_v); end
    stop_btn = 1'b1;
    exp_q.push_back(mk(0, 7, 30, 0, 0, 0, 0)); step(); stop_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL stop_done: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(0, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL done_hold: got %h want %h", obs, exp_v); end
    now_min = 6'd31;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL done_rearm: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_snooze();
    now_min = 6'd30; cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 1, 1, 0, 0)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_ring: got %h want %h", obs, exp_v); end
    snooze_btn = 1'b1;
    exp_q.push_back(mk(0, 7, 35, 0, 0, 1, 1)); step(); snooze_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_rearm: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(1, 7, 35, 0, 0, 1, 1)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_wait: got %h want %h", obs, exp_v); end
    set_hour = 6'd9;
    exp_q.push_back(mk(1, 7, 35, 0, 0, 1, 1)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_set_ignored: got %h want %h", obs, exp_v); end
    cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 35, 1, 1, 0, 1)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_reringing: got %h want %h", obs, exp_v); end
    stop_btn = 1'b1;
    exp_q.push_back(mk(0, 7, 35, 0, 0, 0, 0)); step(); stop_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_stop: got %h want %h", obs, exp_v); end
    now_min = 6'd31;
    exp_q.push_back(mk(1, 9, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL snz_new_set: got %h want %h", obs, exp_v); end
    set_hour = 6'd7;
    step();
  endtask

  task automatic test_wrap();
    now_hour = 6'd23; now_min = 6'd57; cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 1, 1, 0, 0)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_ring: got %h want %h", obs, exp_v); end
    snooze_btn = 1'b1;
    exp_q.push_back(mk(0, 0, 2, 0, 0, 1, 1)); step(); snooze_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_midnight: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(1, 0, 2, 0, 0, 1, 1)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_snooze: got %h want %h", obs, exp_v); end
    now_hour = 6'd10; now_min = 6'd55; cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 0, 2, 1, 1, 0, 1)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_ring2: got %h want %h", obs, exp_v); end
    snooze_btn = 1'b1;
    exp_q.push_back(mk(0, 11, 0, 0, 0, 1, 2)); step(); snooze_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_hour: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(1, 11, 0, 0, 0, 1, 2)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_snooze2: got %h want %h", obs, exp_v); end
    stop_btn = 1'b1;
    exp_q.push_back(mk(0, 11, 0, 0, 0, 0, 0)); step(); stop_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_stop_snooze: got %h want %h", obs, exp_v); end
    now_min = 6'd56;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_rearm: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_timeout();
    int h, m;
    now_hour = 6'd7; now_min = 6'd30;
    for (int k = 0; k < 4; k++) begin
      h = 7; m = (k == 0) ? 30 : 35;
      cmp_alarm = 1'b1;
      exp_q.push_back(mk(1, h, m, 1, 1, 0, k)); step(); cmp_alarm = 1'b0;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL to_ring k=%0d: got %h want %h", k, obs, exp_v); end
      for (int i = 1; i <= 60; i++) begin
        tick_1hz = 1'b1;
        exp_q.push_back(mk(1, h, m, (i % 2) == 0, 1, 0, k)); step(); tick_1hz = 1'b0;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL to_tick k=%0d i=%0d: got %h want %h", k, i, obs, exp_v); end
        if (i < 60) begin
          exp_q.push_back(mk(1, h, m, (i % 2) == 0, 1, 0, k)); step();
          exp_v = exp_q.pop_front(); n_cmp++;
          if (obs !== exp_v) begin n_bad++; $display("FAIL to_idle k=%0d i=%0d: got %h want %h", k, i, obs, exp_v); end
        end
      end
      if (k < 3) begin
        exp_q.push_back(mk(0, 7, 35, 0, 0, 1, k + 1)); step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL to_rearm k=%0d: got %h want %h", k, obs, exp_v); end
        exp_q.push_back(mk(1, 7, 35, 0, 0, 1, k + 1)); step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL to_snooze k=%0d: got %h want %h", k, obs, exp_v); end
      end else begin
        exp_q.push_back(mk(0, 7, 35, 0, 0, 0, 0)); step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL to_done: got %h want %h", obs, exp_v); end
      end
    end
    now_min = 6'd31;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL to_rearm_armed: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 1, 1, 0, 0)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_ring: got %h want %h", obs, exp_v); end
    snooze_btn = 1'b1; stop_btn = 1'b1;
    exp_q.push_back(mk(0, 7, 30, 0, 0, 0, 0)); step(); snooze_btn = 1'b0; stop_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_stop_wins: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(0, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_done_hold: got %h want %h", obs, exp_v); end
    now_min = 6'd32;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_armed: got %h want %h", obs, exp_v); end
    cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 1, 1, 0, 0)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_ring2: got %h want %h", obs, exp_v); end
    snooze_btn = 1'b1;
    exp_q.push_back(mk(0, 7, 37, 0, 0, 1, 1)); step(); snooze_btn = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_rearm: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(1, 7, 37, 0, 0, 1, 1)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_snooze: got %h want %h", obs, exp_v); end
    set_hour = 6'd0; set_min = 6'd0; alarm_enable = 1'b0; cmp_alarm = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); step(); cmp_alarm = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_disable: got %h want %h", obs, exp_v); end
    set_hour = 6'd7; set_min = 6'd30;
    exp_q.push_back(mk(0, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_disabled_track: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    alarm_enable = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ar_armed: got %h want %h", obs, exp_v); end
    cmp_alarm = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 1, 1, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ar_ring: got %h want %h", obs, exp_v); end
    tick_1hz = 1'b1;
    exp_q.push_back(mk(1, 7, 30, 0, 1, 0, 0)); step(); tick_1hz = 1'b0;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ar_tick: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0; #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ar_async_clear: got %h want %h", obs, exp_v); end
    @(negedge clk);
    reset = 1'b1; cmp_alarm = 1'b0;
    exp_q.push_back(mk(1, 7, 30, 0, 0, 0, 0)); step();
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ar_release_armed: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ring_stop();
    test_snooze();
    test_wrap();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
